// File: rtl/instruction_fetch_pkg.sv
// Shared definitions for the LEGv8 instruction fetch stage.
// Holds the fetch FSM state encoding, the instruction size in bytes
// and the default address fetched after reset.
package instruction_fetch_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_VALID = 2'd2,
        S_FAULT = 2'd3
    } fetch_state_t;

    localparam int unsigned INSTR_BYTES      = 4;
    localparam logic [63:0] DEFAULT_RESET_PC = 64'h0;

endpackage

// File: rtl/instruction_fetch_if.sv
// Instruction memory request/acknowledge bus.
//   oMemReq  : fetch stage requests an instruction word
//   oMemAddr : 64-bit fetch address, stable while oMemReq is high
//   iMemAck  : memory returns iMemData this cycle
//   iMemData : 32-bit instruction word, valid with iMemAck
// master = fetch stage, slave = instruction memory.
interface instruction_fetch_if;

    logic        oMemReq;
    logic [63:0] oMemAddr;
    logic        iMemAck;
    logic [31:0] iMemData;

    modport master (
        output oMemReq,
        output oMemAddr,
        input  iMemAck,
        input  iMemData
    );

    modport slave (
        input  oMemReq,
        input  oMemAddr,
        output iMemAck,
        output iMemData
    );

endinterface

// File: rtl/instruction_fetch_next_pc.sv
// fetch_next_pc: combinational next-PC selection for the fetch stage.
//   pc           : address of the instruction being consumed
//   branch_taken : select pc + imm (highest priority)
//   imm          : sign-extended, already x4 branch offset
//   jump_reg     : select reg_target
//   reg_target   : BR target address
//   next_pc      : selected next fetch address
//   misaligned   : next_pc[1:0] != 0 (only with FETCH_ALIGN_CHECK_EN)
// Macro FETCH_ALIGN_CHECK_EN: when defined, misaligned targets are flagged;
// otherwise the low two bits are forced to zero.
module fetch_next_pc
    import instruction_fetch_pkg::*;
(
    input  logic [63:0] pc,
    input  logic        branch_taken,
    input  logic [63:0] imm,
    input  logic        jump_reg,
    input  logic [63:0] reg_target,
    output logic [63:0] next_pc,
    output logic        misaligned
);

    logic [63:0] raw_pc;

    always_comb begin
        raw_pc = pc + 64'(INSTR_BYTES);
        if (branch_taken) begin
            raw_pc = pc + imm;
        end else if (jump_reg) begin
            raw_pc = reg_target;
        end
    end

`ifdef FETCH_ALIGN_CHECK_EN
    assign next_pc    = raw_pc;
    assign misaligned = (raw_pc[1:0] != 2'b00);
`else
    assign next_pc    = raw_pc & ~64'h3;
    assign misaligned = 1'b0;
`endif

endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch: LEGv8 fetch stage. Holds the PC, fetches 32-bit words
// over a req/ack bus and presents them with their PC to decode.
//   iCLK, iRST_n       : clock, asynchronous active-low reset
//   iStall             : downstream not ready, hold presented instruction
//   iBranchTaken       : take pc-relative branch (oPC + iImmediateExtended)
//   iImmediateExtended : branch offset
//   iJumpReg           : register-indirect jump to iRegTarget
//   iRegTarget         : BR target
//   mem                : instruction memory bus (instruction_fetch_if.master)
//   oInstr, oPC        : presented instruction and its address
//   oValid             : oInstr/oPC hold a fetched instruction
//   oMisaligned        : sticky alignment fault
// Macro FETCH_ALIGN_CHECK_EN enables the alignment fault state.
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter logic [63:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic                       iCLK,
    input  logic                       iRST_n,
    input  logic                       iStall,
    input  logic                       iBranchTaken,
    input  logic [63:0]                iImmediateExtended,
    input  logic                       iJumpReg,
    input  logic [63:0]                iRegTarget,
    instruction_fetch_if.master        mem,
    output logic [31:0]                oInstr,
    output logic [63:0]                oPC,
    output logic                       oValid,
    output logic                       oMisaligned
);

    fetch_state_t state, next_state;
    logic [63:0]  fetch_pc;
    logic [63:0]  next_pc;
    logic         next_misaligned;
    logic         capture;
    logic         consume;
    logic         load_next;

    fetch_next_pc u_next_pc (
        .pc           (oPC),
        .branch_taken (iBranchTaken),
        .imm          (iImmediateExtended),
        .jump_reg     (iJumpReg),
        .reg_target   (iRegTarget),
        .next_pc      (next_pc),
        .misaligned   (next_misaligned)
    );

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        capture    = 1'b0;
        consume    = 1'b0;
        load_next  = 1'b0;
        case (state)
            S_IDLE: next_state = S_REQ;
            S_REQ: begin
                if (mem.iMemAck) begin
                    capture    = 1'b1;
                    next_state = S_VALID;
                end
            end
            S_VALID: begin
                if (!iStall) begin
                    consume = 1'b1;
                    // A misaligned target loads nothing; fetch_pc keeps the old value.
                    if (next_misaligned) begin
                        next_state = S_FAULT;
                    end else begin
                        load_next  = 1'b1;
                        next_state = S_REQ;
                    end
                end
            end
            S_FAULT: next_state = S_FAULT;
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            fetch_pc <= RESET_PC;
            oPC      <= RESET_PC;
            oInstr   <= '0;
            oValid   <= 1'b0;
        end else begin
            if (capture) begin
                oInstr <= mem.iMemData;
                oPC    <= fetch_pc;
                oValid <= 1'b1;
            end else if (consume) begin
                oValid <= 1'b0;
            end
            if (load_next) begin
                fetch_pc <= next_pc;
            end
        end
    end

    assign mem.oMemReq  = (state == S_REQ);
    assign mem.oMemAddr = fetch_pc;

`ifdef FETCH_ALIGN_CHECK_EN
    assign oMisaligned = (state == S_FAULT);
`else
    assign oMisaligned = 1'b0;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch with RESET_PC = 0x400.
// A behavioural model tracks the expected fetch address and presented
// instruction; a memory responder with random wait states drives the bus.
module tb_instruction_fetch;

    localparam logic [63:0] RST_PC = 64'h400;

    logic        iCLK = 1'b0;
    logic        iRST_n = 1'b0;
    logic        iStall = 1'b0;
    logic        iBranchTaken = 1'b0;
    logic [63:0] iImmediateExtended = '0;
    logic        iJumpReg = 1'b0;
    logic [63:0] iRegTarget = '0;
    logic [31:0] oInstr;
    logic [63:0] oPC;
    logic        oValid;
    logic        oMisaligned;

    instruction_fetch_if mem_bus ();

    instruction_fetch #(.RESET_PC(RST_PC)) dut (
        .iCLK               (iCLK),
        .iRST_n             (iRST_n),
        .iStall             (iStall),
        .iBranchTaken       (iBranchTaken),
        .iImmediateExtended (iImmediateExtended),
        .iJumpReg           (iJumpReg),
        .iRegTarget         (iRegTarget),
        .mem                (mem_bus.master),
        .oInstr             (oInstr),
        .oPC                (oPC),
        .oValid             (oValid),
        .oMisaligned        (oMisaligned)
    );

    always #5 iCLK = ~iCLK;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    // Reference model state
    logic [63:0] model_pc;
    logic [63:0] model_opc;
    logic [31:0] model_instr;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge iCLK);
        #1;
    endtask

    task automatic apply_reset();
        iRST_n = 1'b0;
        mem_bus.iMemAck = 1'b1;
        step();
        step();
        check_val("rst_req", 64'(mem_bus.oMemReq), 64'd0);
        check_val("rst_valid", 64'(oValid), 64'd0);
        check_val("rst_misaligned", 64'(oMisaligned), 64'd0);
        check_val("rst_opc", oPC, RST_PC);
        check_val("rst_instr", 64'(oInstr), 64'd0);
        mem_bus.iMemAck = 1'b0;
        iRST_n = 1'b1;
        model_pc = RST_PC;
        model_opc = RST_PC;
    endtask

    // Waits for the request, holds it for 'waits' cycles, then acks with a random word.
    task automatic do_fetch(input int unsigned waits);
        logic [31:0] word;
        for (int i = 0; i < 8 && !mem_bus.oMemReq; i++) step();
        check_val("req_seen", 64'(mem_bus.oMemReq), 64'd1);
        check_val("req_addr", mem_bus.oMemAddr, model_pc);
        for (int unsigned w = 0; w < waits; w++) begin
            mem_bus.iMemAck = 1'b0;
            mem_bus.iMemData = $urandom;
            step();
            check_val("wait_req", 64'(mem_bus.oMemReq), 64'd1);
            check_val("wait_addr", mem_bus.oMemAddr, model_pc);
            check_val("wait_valid", 64'(oValid), 64'd0);
        end
        word = $urandom;
        mem_bus.iMemAck = 1'b1;
        mem_bus.iMemData = word;
        step();
        mem_bus.iMemAck = $urandom_range(0, 1);
        mem_bus.iMemData = $urandom;
        model_opc = model_pc;
        model_instr = word;
        check_val("valid_set", 64'(oValid), 64'd1);
        check_val("valid_pc", oPC, model_opc);
        check_val("valid_instr", 64'(oInstr), 64'(model_instr));
        check_val("valid_noreq", 64'(mem_bus.oMemReq), 64'd0);
    endtask

    task automatic stall_cycles(input int unsigned n);
        for (int unsigned s = 0; s < n; s++) begin
            iStall = 1'b1;
            iBranchTaken = $urandom_range(0, 1);
            iJumpReg = $urandom_range(0, 1);
            iImmediateExtended = {$urandom, $urandom};
            iRegTarget = {$urandom, $urandom};
            mem_bus.iMemAck = $urandom_range(0, 1);
            mem_bus.iMemData = $urandom;
            step();
            check_val("stall_valid", 64'(oValid), 64'd1);
            check_val("stall_pc", oPC, model_opc);
            check_val("stall_instr", 64'(oInstr), 64'(model_instr));
            check_val("stall_noreq", 64'(mem_bus.oMemReq), 64'd0);
        end
    endtask

    // Consumes the presented instruction; returns 1 when the model expects a fault.
    task automatic consume(input logic br, input logic [63:0] imm, input logic jr,
                           input logic [63:0] tgt, output logic fault);
        logic [63:0] nxt;
        iStall = 1'b0;
        iBranchTaken = br;
        iImmediateExtended = imm;
        iJumpReg = jr;
        iRegTarget = tgt;
        mem_bus.iMemAck = 1'b0;
        if (br) nxt = model_opc + imm;
        else if (jr) nxt = tgt;
        else nxt = model_opc + 64'd4;
        fault = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
        fault = (nxt[1:0] != 2'b00);
`else
        nxt[1:0] = 2'b00;
`endif
        step();
        iBranchTaken = 1'b0;
        iJumpReg = 1'b0;
        check_val("consume_valid", 64'(oValid), 64'd0);
        check_val("consume_req", 64'(mem_bus.oMemReq), fault ? 64'd0 : 64'd1);
        check_val("consume_misaligned", 64'(oMisaligned), 64'(fault));
        if (!fault) model_pc = nxt;
    endtask

    initial begin
        logic fault;
        logic br, jr;
        logic [63:0] imm, tgt;
        int off;
        mem_bus.iMemAck = 1'b0;
        mem_bus.iMemData = '0;

        apply_reset();
        do_fetch(0);

        consume(1'b0, '0, 1'b0, '0, fault);
        do_fetch(3);
        consume(1'b0, '0, 1'b0, '0, fault);
        do_fetch(3);

        consume(1'b0, '0, 1'b1, 64'h410, fault);
        do_fetch(1);
        consume(1'b1, 64'hFFFF_FFFF_FFFF_FFF0, 1'b1, 64'h800, fault);
        do_fetch(0);
        check_val("branch_redirect", model_opc, 64'h400);

        stall_cycles(5);
        consume(1'b0, '0, 1'b0, '0, fault);
        do_fetch(0);
        check_val("after_stall", oPC, 64'h404);

        consume(1'b0, '0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, fault);
        do_fetch(2);
        consume(1'b0, '0, 1'b0, '0, fault);
        do_fetch(0);
        check_val("wrap_pc", oPC, 64'h0);

        for (int n = 0; n < 40; n++) begin
            stall_cycles($urandom_range(0, 3));
            br = 1'b0;
            jr = $urandom_range(0, 1);
            imm = {$urandom, $urandom};
            tgt = {$urandom, $urandom};
`ifdef FETCH_ALIGN_CHECK_EN
            tgt = tgt & ~64'h3;
`endif
            case ($urandom_range(0, 3))
                0, 1: jr = 1'b0;
                2: begin
                    br = 1'b1;
                    off = (int'($urandom_range(0, 512)) - 256) * 4;
                    imm = 64'(off);
                end
                default: jr = 1'b1;
            endcase
            consume(br, imm, jr, tgt, fault);
            do_fetch($urandom_range(0, 3));
        end

        consume(1'b0, '0, 1'b1, 64'h402, fault);
`ifdef FETCH_ALIGN_CHECK_EN
        for (int i = 0; i < 4; i++) begin
            mem_bus.iMemAck = $urandom_range(0, 1);
            iStall = $urandom_range(0, 1);
            step();
            check_val("fault_sticky", 64'(oMisaligned), 64'd1);
            check_val("fault_valid", 64'(oValid), 64'd0);
            check_val("fault_req", 64'(mem_bus.oMemReq), 64'd0);
        end
        iStall = 1'b0;
        apply_reset();
`else
        check_val("align_forced_pc", model_pc, 64'h400);
`endif
        do_fetch(0);
        check_val("post_align_pc", oPC, 64'h400);

        consume(1'b0, '0, 1'b0, '0, fault);
        mem_bus.iMemAck = 1'b0;
        step();
        check_val("pre_reset_req", 64'(mem_bus.oMemReq), 64'd1);
        iRST_n = 1'b0;
        #1;
        check_val("async_req_drop", 64'(mem_bus.oMemReq), 64'd0);
        check_val("async_valid_drop", 64'(oValid), 64'd0);
        apply_reset();
        do_fetch(1);
        check_val("restart_pc", oPC, RST_PC);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no end expected finish");
        $fatal(1);
    end

endmodule
